// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word requests into word-wide memory accesses,
// with read-modify-write for sub-word stores. Optional macro: MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] word_addr;
`ifdef MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
`endif

    // Selects the addressed lane, moves it to bit 0 and extends it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] res;
        res = old;
        case (size)
            2'b00: res[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) res[31:16] = wd[15:0];
                else         res[15:0]  = wd[15:0];
            end
            default: res = wd;
        endcase
        return res;
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == 2'b01) && lo[0]) || (size[1] && (lo != 2'b00));
    endfunction
`endif

    // Upper address bits beyond the memory index pass through untouched.
    assign word_addr = {addr_q[ADDR_W-1:IDX_W+2], addr_q[IDX_W+1:2], 2'b00};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        signed_d  = signed_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
`ifdef MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    write_d  = req_write;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    state_d  = (req_write && !req_size[1]) ? RMW_RD : ACCESS;
`ifdef MISALIGN_TRAP_EN
                    misalign_d = 1'b0;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        misalign_d = 1'b1;
                        state_d    = DONE;
                    end
`endif
                end
            end
            ACCESS: begin
                mem_addr = word_addr;
                if (write_q) begin
                    mem_write = 1'b1;
                    mem_wdata = wdata_q;
                end else begin
                    mem_read = 1'b1;
                    rdata_d  = load_extend(mem_rdata, addr_q[1:0], size_q, signed_q);
                end
                state_d = DONE;
            end
            RMW_RD: begin
                mem_addr = word_addr;
                mem_read = 1'b1;
                merge_d  = mem_rdata;
                state_d  = RMW_WR;
            end
            RMW_WR: begin
                mem_addr  = word_addr;
                mem_write = 1'b1;
                mem_wdata = store_merge(merge_q, wdata_q, addr_q[1:0], size_q);
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: mem_read/mem_write decode straight from state_q, so the async reset drops them
    // immediately and a half-finished RMW write never reaches the memory's negedge sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign done  = (state_q == DONE);
    assign stall = req_valid & ~done;
    assign rdata = rdata_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_err = done & misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a negedge-write word memory model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, misalign_err, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [32];

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.ADDR_W(32), .MEM_WORDS(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata), .misalign_err(misalign_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr[6:2]];
    always @(negedge clock) if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request from IDLE (called at posedge+1) and follows it to done.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output int n_rd,
                          output int n_wr, output int n_stall, output logic [31:0] last_wd,
                          output logic [31:0] last_addr, output logic err,
                          output logic stall_at_done);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        lat = 0; rd = 'x; n_rd = 0; n_wr = 0; last_wd = 'x; last_addr = 'x;
        err = 1'b0; stall_at_done = 1'bx;
        #1;
        n_stall = int'(stall);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            lat++;
            if (mem_read || mem_write) last_addr = mem_addr;
            if (mem_read)  n_rd++;
            if (mem_write) begin n_wr++; last_wd = mem_wdata; end
            if (done) begin
                rd = rdata; err = misalign_err; stall_at_done = stall;
                break;
            end
            n_stall += int'(stall);
        end
        req_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    int          lat, n_rd, n_wr, n_stall;
    logic [31:0] rd, last_wd, last_addr;
    logic        err, sad;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[3] = 32'h8899AABB;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        #1;
        check("rst_mem_read",  {31'd0, mem_read},     32'd0);
        check("rst_mem_write", {31'd0, mem_write},    32'd0);
        check("rst_done",      {31'd0, done},         32'd0);
        check("rst_misalign",  {31'd0, misalign_err}, 32'd0);
        check("rst_rdata",     rdata,                 32'd0);
        check("rst_stall",     {31'd0, stall},        32'd0);
        #11 reset_n = 1'b1;
        @(posedge clock); #1;

        // 1: word load
        do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
        check("lw_lat",   lat,       32'd2);
        check("lw_rdata", rd,        32'h8899AABB);
        check("lw_nrd",   n_rd,      32'd1);
        check("lw_nwr",   n_wr,      32'd0);
        check("lw_addr",  last_addr, 32'h0C);
        check("lw_stall", n_stall,   32'd2);
        check("lw_stall_done", {31'd0, sad}, 32'd0);

        // 2: sub-word loads
        do_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
        check("lb_s_rdata", rd, 32'hFFFFFFAA);
        check("lb_s_addr",  last_addr, 32'h0C);
        do_req(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
        check("lb_u_rdata", rd, 32'h000000AA);
        do_req(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
        check("lh_s_rdata", rd, 32'hFFFF8899);
        do_req(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
        check("lh_lo_rdata", rd, 32'hFFFFAABB);
        do_req(1'b0, 2'b00, 1'b1, 32'h0F, 32'h0, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
        check("lb3_s_rdata", rd, 32'hFFFFFF88);
        do_req(1'b0, 2'b11, 1'b1, 32'h0C, 32'h0, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
        check("lrsv_rdata", rd, 32'h8899AABB);

        // 3: byte store via RMW
        do_req(1'b1, 2'b00, 1'b0, 32'h0E, 32'hFFFFFF55, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
        check("sb_lat",   lat,     32'd3);
        check("sb_nrd",   n_rd,    32'd1);
        check("sb_nwr",   n_wr,    32'd1);
        check("sb_wdata", last_wd, 32'h8855AABB);
        check("sb_stall", n_stall, 32'd3);
        check("sb_stall_done", {31'd0, sad}, 32'd0);
        check("sb_mem",   mem[3],  32'h8855AABB);

        // 4: word store then load of the same address
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
        check("sw_lat",   lat,     32'd2);
        check("sw_nrd",   n_rd,    32'd0);
        check("sw_nwr",   n_wr,    32'd1);
        check("sw_stall", n_stall, 32'd2);
        check("sw_stall_done", {31'd0, sad}, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
        check("lw2_rdata", rd,      32'hDEADBEEF);
        check("lw2_stall", n_stall, 32'd2);

        // 5: reset during RMW_WR of a halfword store
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h00001234;
        @(posedge clock); #1;
        check("rmw_rd_read", {31'd0, mem_read}, 32'd1);
        @(posedge clock); #1;
        check("rmw_wr_write", {31'd0, mem_write}, 32'd1);
        check("rmw_wr_wdata", mem_wdata, 32'h1234BEEF);
        reset_n = 1'b0;
        #1;
        check("rst_mid_write", {31'd0, mem_write}, 32'd0);
        check("rst_mid_read",  {31'd0, mem_read},  32'd0);
        #12 reset_n = 1'b1;
        #1;
        check("post_rst_done",  {31'd0, done},  32'd0);
        check("post_rst_stall", {31'd0, stall}, 32'd1);
        req_valid = 1'b0;
        #1;
        check("post_rst_stall0", {31'd0, stall}, 32'd0);
        check("post_rst_mem",    mem[4], 32'hDEADBEEF);
        @(posedge clock); #1;
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
        check("post_rst_lat",   lat, 32'd2);
        check("post_rst_rdata", rd,  32'hDEADBEEF);

        // 6: misaligned word load
        do_req(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, lat, rd, n_rd, n_wr, n_stall, last_wd, last_addr, err, sad);
`ifdef MISALIGN_TRAP_EN
        check("mis_lat",   lat,             32'd1);
        check("mis_err",   {31'd0, err},    32'd1);
        check("mis_rdata", rd,              32'd0);
        check("mis_nrd",   n_rd,            32'd0);
        check("mis_nwr",   n_wr,            32'd0);
`else
        check("mis_lat",   lat,             32'd2);
        check("mis_err",   {31'd0, err},    32'd0);
        check("mis_rdata", rd,              32'h8855AABB);
        check("mis_nrd",   n_rd,            32'd1);
        check("mis_addr",  last_addr,       32'h0C);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
